i2c_master_burst: RTL

- Parametrised successor to the single-byte I2C write engine: a full I2C master supporting write and read bursts of 0..2^CNT_W-1 bytes.
- Adds a programmable SCL divider, real ACK sampling and a NACK error report.
- Drives open-drain SCL/SDA enables to the pad ring; sits between the host control logic and the board I2C bus.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_quarter_tick.sv | 36 +++
 rtl/i2c_master_burst.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C burst master: FSM states, quarter phases and slot constants.
package i2c_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle  = 4'd0;
  localparam state_t StStart = 4'd1;
  localparam state_t StAddr  = 4'd2;
  localparam state_t StAack  = 4'd3;
  localparam state_t StWdata = 4'd4;
  localparam state_t StWack  = 4'd5;
  localparam state_t StRdata = 4'd6;
  localparam state_t StRack  = 4'd7;
  localparam state_t StStop  = 4'd8;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int unsigned AddrBits = 8;
  // Index of the final bit slot of an address/data byte.
  localparam logic [2:0]  LastBit  = 3'(AddrBits - 1);

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL timebase: divides clk by DIV into quarter ticks and tracks the 2-bit quarter phase.
module i2c_quarter_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] DivMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [1:0]      phase_q;

  assign tick  = run && (cnt_q == DivMax);
  assign phase = phase_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else if (!run) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= phase_q + 2'd1;
    end else begin
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_burst.sv
// I2C master with write/read bursts, programmable SCL divider, ACK sampling and NACK reporting.
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [CNT_W-1:0] nbytes,
  input  logic [7:0]       wdata,
  output logic             wdata_ack,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             scl_oe,
  output logic             ready,
  output logic             done,
  output logic             nack
);

  state_t           state_q, state_d;
  logic [7:0]       sh_q;
  logic [6:0]       rx_q;
  logic [7:0]       rdata_q;
  logic [2:0]       bit_q;
  logic [CNT_W-1:0] rem_q, rem_dec;
  logic             rw_q, samp_q, nack_q, done_q, ready_q, wdata_ack_q, rdata_valid_q;
  logic             run, tick, slot_end, samp_edge, accept, last_bit;
  logic [1:0]       phase;

  i2c_quarter_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick),
    .phase(phase)
  );

  assign run       = (state_q != StIdle);
  assign slot_end  = tick && (phase == Q3);
  assign samp_edge = tick && (phase == Q2);
  assign accept    = start && ready_q;
  assign last_bit  = (bit_q == LastBit);
  assign rem_dec   = (rem_q != '0) ? rem_q - CNT_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StStart;
      StStart: if (slot_end) state_d = StAddr;
      StAddr:  if (slot_end && last_bit) state_d = StAack;
      StAack: begin
        if (slot_end) begin
          if (samp_q || rem_q == '0) state_d = StStop;
          else if (rw_q)             state_d = StRdata;
          else                       state_d = StWdata;
        end
      end
      StWdata: if (slot_end && last_bit) state_d = StWack;
      StWack:  if (slot_end) state_d = (samp_q || rem_dec == '0) ? StStop : StWdata;
      StRdata: if (slot_end && last_bit) state_d = StRack;
      StRack:  if (slot_end) state_d = (rem_dec == '0) ? StStop : StRdata;
      StStop:  if (slot_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      sh_q          <= '0;
      rx_q          <= '0;
      rdata_q       <= '0;
      bit_q         <= '0;
      rem_q         <= '0;
      rw_q          <= 1'b0;
      samp_q        <= 1'b0;
      nack_q        <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
      wdata_ack_q   <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= (state_q == StStop) && slot_end;
      // ready re-asserts one cycle after the done pulse.
      ready_q       <= (state_q == StIdle) && !accept;
      wdata_ack_q   <= 1'b0;
      rdata_valid_q <= 1'b0;
      if (accept) begin
        sh_q   <= {addr, rw};
        rw_q   <= rw;
        rem_q  <= nbytes;
        nack_q <= 1'b0;
        bit_q  <= '0;
      end
      if (samp_edge) begin
        samp_q <= sda_i;
        if (state_q == StRdata) begin
          rx_q <= {rx_q[5:0], sda_i};
          if (last_bit) begin
            rdata_q       <= {rx_q, sda_i};
            rdata_valid_q <= 1'b1;
          end
        end
      end
      if (slot_end) begin
        if (state_q == StAddr || state_q == StWdata || state_q == StRdata) begin
          bit_q <= bit_q + 3'd1;
          sh_q  <= {sh_q[6:0], 1'b0};
        end
        if ((state_q == StAack || state_q == StWack) && samp_q) nack_q <= 1'b1;
        if (state_q == StWack || state_q == StRack) rem_q <= rem_dec;
        // Each write byte is fetched as its first slot begins.
        if (state_d == StWdata && state_q != StWdata) begin
          sh_q        <= wdata;
          wdata_ack_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    sda_oe = 1'b0;
    scl_oe = 1'b0;
    case (state_q)
      StStart: begin
        sda_oe = (phase >= Q2);
        scl_oe = (phase == Q3);
      end
      StAddr, StWdata: begin
        sda_oe = !sh_q[7];
        scl_oe = (phase <= Q1);
      end
      StAack, StWack, StRdata: scl_oe = (phase <= Q1);
      StRack: begin
        sda_oe = (rem_q > CNT_W'(1));
        scl_oe = (phase <= Q1);
      end
      StStop: begin
        sda_oe = (phase != Q3);
        scl_oe = (phase <= Q1);
      end
      default: ;
    endcase
  end

  assign wdata_ack   = wdata_ack_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign ready       = ready_q;
  assign done        = done_q;
  assign nack        = nack_q;

endmodule
